// File: rtl/sbox_builder_if.sv
// Candidate stream and table-lookup bundle for sbox_builder.
// Master drives candidates and lookup requests; slave (the builder) returns ready and lookup data.
interface sbox_builder_if #(
  parameter int SW     = 8,
  parameter int CAND_W = 23
);
  logic              cand_valid;
  logic [CAND_W-1:0] cand_data;
  logic              cand_ready;
  logic              rd_en;
  logic              rd_inv;
  logic [SW-1:0]     rd_addr;
  logic [SW-1:0]     rd_data;
  logic              rd_valid;

  modport master (
    output cand_valid, cand_data, rd_en, rd_inv, rd_addr,
    input  cand_ready, rd_data, rd_valid
  );

  modport slave (
    input  cand_valid, cand_data, rd_en, rd_inv, rd_addr,
    output cand_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/sbox_builder.sv
// Fills an SW-bit S-box (forward and optional inverse table) from chaotic candidates, dropping duplicate symbols.
// Lookups answer one cycle after the request; candidates are taken only while filling (cand_ready = busy).
module sbox_builder #(
  parameter int SW      = 8,
  parameter int CAND_W  = 23,
  parameter int SEL_LSB = 0,
  parameter bit GEN_INV = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  sbox_builder_if.slave bus,
  output logic          o_busy,
  output logic          o_done,
  output logic [SW:0]   o_fill_cnt,
  output logic [15:0]   o_dup_cnt
);
  localparam int          DEPTH    = 1 << SW;
  localparam logic [SW:0] LAST_IDX = (SW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DEPTH-1:0] r_seen;
  logic [SW:0]      r_fill_cnt;
  logic [15:0]      r_dup_cnt;
  logic [SW-1:0]    r_fwd [DEPTH];
  logic [SW-1:0]    r_rd_data;
  logic             r_rd_valid;
  logic [SW-1:0]    w_sym;
  logic [SW-1:0]    w_inv_rd;
  logic             w_start;
  logic             w_xfer;
  logic             w_new;
  logic             w_last;
  logic             w_rd_hit;
  logic             w_unused;

  assign w_sym    = bus.cand_data[SEL_LSB +: SW];
  assign w_start  = i_start && (r_state != S_FILL);
  assign w_xfer   = bus.cand_valid && (r_state == S_FILL);
  assign w_new    = w_xfer && !r_seen[w_sym];
  assign w_last   = w_new && (r_fill_cnt == LAST_IDX);
  assign w_rd_hit = bus.rd_en && (r_state == S_DONE);
  assign w_unused = ^bus.cand_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_FILL;
      S_FILL: begin
        o_busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        if (w_start) w_state_nxt = S_FILL;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.cand_ready = o_busy;

  // A start clears the bookkeeping; tables are simply overwritten by the next build.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_seen     <= '0;
      r_fill_cnt <= '0;
      r_dup_cnt  <= '0;
    end else if (w_start) begin
      r_seen     <= '0;
      r_fill_cnt <= '0;
      r_dup_cnt  <= '0;
    end else if (w_new) begin
      r_seen[w_sym] <= 1'b1;
      r_fill_cnt    <= r_fill_cnt + (SW+1)'(1);
    end else if (w_xfer && (r_dup_cnt != 16'hFFFF)) begin
      r_dup_cnt <= r_dup_cnt + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_new) r_fwd[r_fill_cnt[SW-1:0]] <= w_sym;
  end

  generate
    if (GEN_INV) begin : g_inv
      logic [SW-1:0] r_inv [DEPTH];
      always_ff @(posedge i_clk) begin
        if (w_new) r_inv[w_sym] <= r_fill_cnt[SW-1:0];
      end
      assign w_inv_rd = r_inv[bus.rd_addr];
    end else begin : g_no_inv
      assign w_inv_rd = r_fwd[bus.rd_addr];
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_hit;
      if (w_rd_hit) r_rd_data <= bus.rd_inv ? w_inv_rd : r_fwd[bus.rd_addr];
      else          r_rd_data <= '0;
    end
  end

  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_data;
  assign o_fill_cnt   = r_fill_cnt;
  assign o_dup_cnt    = r_dup_cnt;
endmodule
